mem_pattern_tester: RTL and testbench



---
 rtl/mem_pattern_tester.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mem_pattern_tester.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pattern_tester.sv
// mem_pattern_tester: self-checking DRAM exerciser on the host clock domain.
// It writes a selectable pattern over a word range, waits for the write path to drain,
// reads the range back through the read-address / read-data FIFOs and compares every
// returned word against a locally regenerated copy of the pattern.
//
// Ports:
//   clk, rst        host clock, asynchronous active-high reset
//   start           level request to begin a run (honoured only when idle or done)
//   pattern_sel     0: addr, 1: ~addr, 2: Galois LFSR, 3: walking one (latched at start)
//   haddr           word address for the current write or read request
//   busy            write FIFO or read-address FIFO full
//   wr_enable       write push strobe, wr_data carries the word
//   rd_enable       read-address push strobe
//   rd_data, rd_rdy head of the read-data FIFO and its not-empty flag
//   rd_ack          read-data pop strobe
//   done, pass      run finished / finished cleanly
//   timeout         read phase aborted by the watchdog
//   err_count       saturating mismatch count
//   first_err_addr  address of the first mismatching word
module mem_pattern_tester #(
  parameter int unsigned HADDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_START   = 0,
  parameter int unsigned ADDR_COUNT   = 256,
  parameter int unsigned MAX_OUTST    = 4,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned TIMEOUT      = 4096,
  parameter logic [15:0] SEED         = 16'hA5C3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             pattern_sel,
  output logic [HADDR_WIDTH-1:0] haddr,
  input  logic                   busy,
  output logic                   wr_enable,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   rd_enable,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_rdy,
  output logic                   rd_ack,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [15:0]            err_count,
  output logic [HADDR_WIDTH-1:0] first_err_addr
);

  localparam int unsigned IdxW = $clog2(ADDR_COUNT + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTST + 1);
  localparam int unsigned DrW  = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  localparam logic [IdxW-1:0]        Count     = IdxW'(ADDR_COUNT);
  localparam logic [IdxW-1:0]        LastIdx   = IdxW'(ADDR_COUNT - 1);
  localparam logic [OutW-1:0]        MaxOut    = OutW'(MAX_OUTST);
  localparam logic [DrW-1:0]         DrainLast = DrW'(DRAIN_CYCLES - 1);
  localparam logic [WdW-1:0]         WdLast    = WdW'(TIMEOUT - 1);
  localparam logic [HADDR_WIDTH-1:0] Base      = HADDR_WIDTH'(ADDR_START);

  typedef enum logic [2:0] {StIdle, StWrite, StDrain, StRead, StDone} state_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] pat_word(input logic [1:0]  sel,
                                           input logic [15:0] a,
                                           input logic [15:0] lfsr);
    logic [15:0] w;
    case (sel)
      2'd0:    w = a;
      2'd1:    w = ~a;
      2'd2:    w = lfsr;
      default: w = 16'h0001 << a[3:0];
    endcase
    return w;
  endfunction

  state_e                 state_q, state_d;
  logic [1:0]             sel_q, sel_d;
  // Shared request index: write index during WRITE, issue index during READ.
  logic [IdxW-1:0]        req_idx_q, req_idx_d;
  logic [15:0]            req_lfsr_q, req_lfsr_d;
  logic [IdxW-1:0]        chk_idx_q, chk_idx_d;
  logic [15:0]            chk_lfsr_q, chk_lfsr_d;
  logic [DrW-1:0]         drain_q, drain_d;
  logic [OutW-1:0]        outst_q, outst_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic                   ack_q, ack_d;
  logic [15:0]            err_q, err_d;
  logic [HADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;

  logic [HADDR_WIDTH-1:0] req_addr;
  logic [HADDR_WIDTH-1:0] chk_addr;
  logic [DATA_WIDTH-1:0]  req_word;
  logic [DATA_WIDTH-1:0]  exp_word;

  assign req_addr = Base + HADDR_WIDTH'(req_idx_q);
  assign chk_addr = Base + HADDR_WIDTH'(chk_idx_q);
  assign req_word = DATA_WIDTH'(pat_word(sel_q, 16'(req_addr), req_lfsr_q));
  assign exp_word = DATA_WIDTH'(pat_word(sel_q, 16'(chk_addr), chk_lfsr_q));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    req_idx_d  = req_idx_q;
    req_lfsr_d = req_lfsr_q;
    chk_idx_d  = chk_idx_q;
    chk_lfsr_d = chk_lfsr_q;
    drain_d    = drain_q;
    outst_d    = outst_q;
    wd_d       = wd_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    haddr      = '0;
    wr_enable  = 1'b0;
    wr_data    = '0;
    rd_enable  = 1'b0;
    rd_ack     = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StWrite;
          sel_d      = pattern_sel;
          req_idx_d  = '0;
          req_lfsr_d = SEED;
          chk_idx_d  = '0;
          chk_lfsr_d = SEED;
          drain_d    = '0;
          outst_d    = '0;
          wd_d       = '0;
          err_d      = '0;
          ferr_d     = '0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      StWrite: begin
        haddr   = req_addr;
        wr_data = req_word;
        if (!busy) begin
          wr_enable  = 1'b1;
          req_idx_d  = req_idx_q + IdxW'(1);
          req_lfsr_d = lfsr_next(req_lfsr_q);
          if (req_idx_q == LastIdx) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end

      StDrain: begin
        // Only an unbroken run of non-busy cycles counts as drained.
        if (busy) begin
          drain_d = '0;
        end else if (drain_q == DrainLast) begin
          state_d   = StRead;
          req_idx_d = '0;
          chk_idx_d = '0;
          outst_d   = '0;
          wd_d      = '0;
        end else begin
          drain_d = drain_q + DrW'(1);
        end
      end

      StRead: begin
        haddr     = req_addr;
        rd_enable = !busy && (outst_q < MaxOut) && (req_idx_q < Count);
        // Skip a cycle after each pop so the FIFO head has time to advance.
        rd_ack    = rd_rdy && !ack_q;

        if (rd_enable) begin
          req_idx_d = req_idx_q + IdxW'(1);
        end

        if (rd_ack) begin
          chk_idx_d  = chk_idx_q + IdxW'(1);
          chk_lfsr_d = lfsr_next(chk_lfsr_q);
          if (rd_data != exp_word) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            // err_q never returns to zero, so zero marks the first mismatch.
            if (err_q == 16'd0) begin
              ferr_d = chk_addr;
            end
          end
        end

        if (rd_enable && !rd_ack) begin
          outst_d = outst_q + OutW'(1);
        end else if (!rd_enable && rd_ack) begin
          outst_d = outst_q - OutW'(1);
        end

        if (rd_enable || rd_ack) begin
          wd_d = '0;
        end else if (wd_q == WdLast) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StDone;
        end else begin
          wd_d = wd_q + WdW'(1);
        end

        if (rd_ack && (chk_idx_q == LastIdx)) begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign ack_d = rd_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      req_idx_q  <= '0;
      req_lfsr_q <= '0;
      chk_idx_q  <= '0;
      chk_lfsr_q <= '0;
      drain_q    <= '0;
      outst_q    <= '0;
      wd_q       <= '0;
      ack_q      <= 1'b0;
      err_q      <= '0;
      ferr_q     <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      req_idx_q  <= req_idx_d;
      req_lfsr_q <= req_lfsr_d;
      chk_idx_q  <= chk_idx_d;
      chk_lfsr_q <= chk_lfsr_d;
      drain_q    <= drain_d;
      outst_q    <= outst_d;
      wd_q       <= wd_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign done           = done_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign pass           = done_q && (err_q == 16'd0) && !timeout_q;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// tb_mem_pattern_tester: randomized bench for mem_pattern_tester with an ideal
// in-order memory model that can corrupt or drop responses, and a scoreboard that
// derives every expected word from the pattern definitions.
module tb_mem_pattern_tester;

  localparam int unsigned HAW = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned AS  = 0;
  localparam int unsigned AC  = 8;
  localparam int unsigned MO  = 4;
  localparam int unsigned DC  = 16;
  localparam int unsigned TO  = 64;
  localparam logic [15:0] SD  = 16'hA5C3;

  logic           clk;
  logic           rst;
  logic           start;
  logic [1:0]     pattern_sel;
  logic [HAW-1:0] haddr;
  logic           busy;
  logic           wr_enable;
  logic [DW-1:0]  wr_data;
  logic           rd_enable;
  logic [DW-1:0]  rd_data;
  logic           rd_rdy;
  logic           rd_ack;
  logic           done;
  logic           pass;
  logic           timeout;
  logic [15:0]    err_count;
  logic [HAW-1:0] first_err_addr;

  mem_pattern_tester #(
    .HADDR_WIDTH (HAW),
    .DATA_WIDTH  (DW),
    .ADDR_START  (AS),
    .ADDR_COUNT  (AC),
    .MAX_OUTST   (MO),
    .DRAIN_CYCLES(DC),
    .TIMEOUT     (TO),
    .SEED        (SD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pattern_sel   (pattern_sel),
    .haddr         (haddr),
    .busy          (busy),
    .wr_enable     (wr_enable),
    .wr_data       (wr_data),
    .rd_enable     (rd_enable),
    .rd_data       (rd_data),
    .rd_rdy        (rd_rdy),
    .rd_ack        (rd_ack),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected word i of a run, straight from the pattern definitions.
  function automatic logic [15:0] ref_word(input logic [1:0] sel, input int i);
    int          a;
    int          taps[4];
    logic [15:0] l;
    logic        fb;
    a = (AS + i) % (1 << HAW);
    case (sel)
      2'd0: return a[15:0];
      2'd1: return ~a[15:0];
      2'd2: begin
        taps = '{16, 14, 13, 11};
        l = SD;
        for (int s = 0; s < i; s++) begin
          fb = l[0];
          l  = l >> 1;
          if (fb) begin
            for (int t = 0; t < 4; t++) l[taps[t] - 1] = ~l[taps[t] - 1];
          end
        end
        return l;
      end
      default: return 16'(1 << (a % 16));
    endcase
  endfunction

  typedef struct {
    logic [15:0] data;
    int          rdy_k;
  } resp_t;

  logic [15:0] mem [256];
  resp_t       rq[$];

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_err"}, first_err_addr, 0);
    check({tag, "_strobes"}, {wr_enable, rd_enable, rd_ack}, 0);
    check({tag, "_haddr"}, haddr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  // busy_mode: 0 never busy, 1 random, 2 ten-cycle windows mid-write and mid-read.
  task automatic run_test(input logic [1:0] sel, input int busy_mode, input bit corrupt,
                          input bit drop, input bit poke_start, input bit abort_rd);
    int          widx, ridx, cidx, outst, exp_err, idle;
    int          first_rd_k, last_wr_k, last_ack_k;
    logic [23:0] exp_first;
    logic [15:0] d;
    resp_t       r;
    bit          prev_ack, finished, aborted;
    widx = 0; ridx = 0; cidx = 0; outst = 0; exp_err = 0; idle = 0;
    first_rd_k = -1; last_wr_k = -1; last_ack_k = -1;
    exp_first = '0; prev_ack = 0; finished = 0; aborted = 0;
    rq.delete();

    @(negedge clk);
    start = 1'b1; pattern_sel = sel; busy = 1'b0; rd_rdy = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start = poke_start && (k == 4);
      pattern_sel = 2'($urandom);
      case (busy_mode)
        0: busy = 1'b0;
        1: busy = ($urandom_range(0, 9) < 3);
        default: busy = (k >= 3 && k < 13) ||
                        (first_rd_k > 0 && k >= first_rd_k + 2 && k < first_rd_k + 12);
      endcase
      if (rq.size() > 0 && rq[0].rdy_k <= k) begin
        rd_rdy = 1'b1; rd_data = rq[0].data;
      end else begin
        rd_rdy = 1'b0; rd_data = 16'($urandom);
      end
      #1;
      if (done) begin
        check("final_err_count", err_count, exp_err);
        check("final_first_err_addr", first_err_addr, exp_first);
        check("final_timeout", timeout, 32'(drop));
        check("final_pass", pass, 32'(!drop && exp_err == 0));
        check("final_words_checked", cidx, drop ? AC - 1 : AC);
        check("final_words_written", widx, AC);
        check("final_strobes", {wr_enable, rd_enable, rd_ack}, 0);
        if (drop) check("timeout_idle_cycles", idle, TO);
        else      check("done_after_last_ack", k - last_ack_k, 1);
        finished = 1;
        break;
      end
      if (k == 1) begin
        check("start_clears_err", err_count, 0);
        check("start_clears_timeout", timeout, 0);
        check("first_write_latency", wr_enable, 32'(!busy));
      end
      if (busy) begin
        check("busy_blocks_push", {wr_enable, rd_enable}, 0);
        if (widx < AC) check("busy_haddr_hold", haddr, AS + widx);
      end
      if (wr_enable) begin
        check("wr_addr", haddr, AS + widx);
        check("wr_data", wr_data, ref_word(sel, widx));
        mem[haddr[7:0]] = wr_data;
        widx++;
        last_wr_k = k;
      end
      if (rd_enable) begin
        if (first_rd_k < 0) begin
          first_rd_k = k;
          check("writes_before_reads", widx, AC);
          if (busy_mode == 0) check("drain_gap", k - last_wr_k, DC + 1);
        end
        check("rd_addr", haddr, AS + ridx);
        d = mem[haddr[7:0]];
        if (corrupt && haddr == 5) d[0] = ~d[0];
        if (!(drop && haddr == 3)) begin
          r.data = d; r.rdy_k = k + int'($urandom_range(1, 4));
          rq.push_back(r);
        end
        ridx++;
        outst++;
        check("outstanding_limit", 32'(outst <= MO), 1);
      end
      if (rd_ack) begin
        check("ack_spacing", prev_ack, 0);
        check("ack_needs_rdy", rd_rdy, 1);
        if (rd_rdy) begin
          r = rq.pop_front();
          if (r.data != ref_word(sel, cidx)) begin
            if (exp_err == 0) exp_first = 24'(AS + cidx);
            exp_err++;
          end
        end
        cidx++;
        outst--;
        last_ack_k = k;
        if (abort_rd && cidx == 2) begin
          #2 rst = 1'b1;
          #1 check_all_zero("reset_in_read");
          @(negedge clk);
          rst = 1'b0; rd_rdy = 1'b0;
          rq.delete();
          aborted = 1;
          break;
        end
      end
      prev_ack = rd_ack;
      if (first_rd_k > 0) idle = (rd_enable || rd_ack) ? 0 : idle + 1;
    end
    if (!aborted) begin
      check("run_completed", finished, 1);
      // Done holds, and neither pushes nor acks appear even with rd_rdy high.
      for (int h = 0; h < 4; h++) begin
        @(negedge clk);
        start = 1'b0; busy = 1'b0; rd_rdy = 1'b1;
        #1;
        check("done_held", done, 1);
        check("idle_strobes", {wr_enable, rd_enable, rd_ack}, 0);
      end
      rd_rdy = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pattern_sel = 2'd0; busy = 1'b0;
    rd_rdy = 1'b0; rd_data = '0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_test(2'd0, 0, 0, 0, 1, 0);
    run_test(2'd2, 0, 0, 0, 0, 0);
    run_test(2'd1, 0, 1, 0, 0, 0);
    run_test(2'd3, 2, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) run_test(2'($urandom), 1, 0, 0, n[0], 0);
    run_test(2'd0, 0, 0, 1, 0, 0);
    run_test(2'd2, 1, 0, 0, 0, 1);
    run_test(2'd2, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
